// File: rtl/trap_checkpoint_monitor_if.sv
// trap_checkpoint_monitor_if: config, retire-stream and status bundle for trap_checkpoint_monitor
// master drives cfg_* (checkpoint table write), tmo_lim, start, retire_*, mstatus_mie, mepc;
// slave returns busy, pass, fail, fail_idx, fail_code and hit_cnt.
interface trap_checkpoint_monitor_if #(
  parameter int XLEN  = 32,
  parameter int NCHK  = 4,
  parameter int TMO_W = 16,
  parameter int CNT_W = 8
);
  localparam int IDX_W = NCHK > 1 ? $clog2(NCHK) : 1;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [1:0]       cfg_mode;
  logic [XLEN-1:0]  cfg_pc;
  logic             cfg_mie;
  logic [XLEN-1:0]  cfg_epc;
  logic [TMO_W-1:0] tmo_lim;
  logic             start;
  logic             retire_valid;
  logic [XLEN-1:0]  retire_pc;
  logic             mstatus_mie;
  logic [XLEN-1:0]  mepc;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [IDX_W-1:0] fail_idx;
  logic [2:0]       fail_code;
  logic [CNT_W-1:0] hit_cnt;
  modport master (
    output cfg_we, cfg_idx, cfg_mode, cfg_pc, cfg_mie, cfg_epc, tmo_lim, start,
           retire_valid, retire_pc, mstatus_mie, mepc,
    input  busy, pass, fail, fail_idx, fail_code, hit_cnt
  );
  modport slave (
    input  cfg_we, cfg_idx, cfg_mode, cfg_pc, cfg_mie, cfg_epc, tmo_lim, start,
           retire_valid, retire_pc, mstatus_mie, mepc,
    output busy, pass, fail, fail_idx, fail_code, hit_cnt
  );
endinterface

// File: rtl/trap_checkpoint_monitor.sv
// trap_checkpoint_monitor: checks MIE/mepc at programmed retire PCs, reports sticky pass/fail
// clk, reset (async, active-high); bus: slave side of trap_checkpoint_monitor_if.
// The retire stream is registered once before evaluation, so a retire sampled at edge t
// shows up in pass/fail/hit_cnt after edge t+1.
module trap_checkpoint_monitor #(
  parameter int XLEN    = 32,
  parameter int NCHK    = 4,
  parameter bit ORDERED = 1'b1,
  parameter int TMO_W   = 16,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic reset,
  trap_checkpoint_monitor_if.slave bus
);
  localparam int IDX_W = NCHK > 1 ? $clog2(NCHK) : 1;
  typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_t;
  state_t           r_state, w_state_nx;
  logic [1:0]       r_mode [NCHK];
  logic [XLEN-1:0]  r_pc   [NCHK];
  logic [XLEN-1:0]  r_epc  [NCHK];
  logic [NCHK-1:0]  r_mie, r_hit;
  logic             r_rv, r_rmie;
  logic [XLEN-1:0]  r_rpc, r_repc;
  logic [TMO_W-1:0] r_tmo, w_tmo_nx;
  logic             r_pass, r_fail;
  logic [IDX_W-1:0] r_fidx, w_fidx;
  logic [2:0]       r_fcode, w_fcode;
  logic [CNT_W-1:0] r_hcnt, w_hcnt;
  logic [NCHK-1:0]  w_en, w_match, w_pend, w_first, w_chk, w_bad, w_ord, w_new, w_hit_nx;
  logic [1:0]       w_mm [NCHK];
  logic             w_viol, w_done, w_tmo;
  int               w_pop;
  always_comb begin
    w_fidx  = '0;
    w_fcode = '0;
    w_pop   = 0;
    for (int k = 0; k < NCHK; k++) begin
      w_en[k]    = |r_mode[k];
      w_match[k] = r_rv && w_en[k] && r_rpc == r_pc[k];
      w_mm[k]    = {r_mode[k][1] && r_repc != r_epc[k], r_mode[k][0] && r_rmie != r_mie[k]};
    end
    // lowest un-hit enabled entry, one-hot: the ordered-mode pointer
    w_pend  = w_en & ~r_hit;
    w_first = w_pend & (~w_pend + NCHK'(1));
    w_chk   = ORDERED ? w_match & w_first : w_match;
    w_ord   = ORDERED ? w_match & w_pend & ~w_first : '0;
    for (int k = 0; k < NCHK; k++) w_bad[k] = w_chk[k] && |w_mm[k];
    // descending scans so the lowest index is kept; mismatch scan last so it beats order
    for (int k = NCHK - 1; k >= 0; k--)
      if (w_ord[k]) begin
        w_fidx  = IDX_W'(k);
        w_fcode = 3'd4;
      end
    for (int k = NCHK - 1; k >= 0; k--)
      if (w_bad[k]) begin
        w_fidx  = IDX_W'(k);
        w_fcode = {1'b0, w_mm[k]};
      end
    w_viol   = |w_bad || |w_ord;
    w_new    = w_chk & ~r_hit;
    w_hit_nx = r_hit | w_new;
    w_done   = ~|(w_en & ~w_hit_nx);
    w_tmo_nx = |w_new ? '0 : r_tmo + TMO_W'(1);
    w_tmo    = |bus.tmo_lim && w_tmo_nx == bus.tmo_lim;
    for (int k = 0; k < NCHK; k++) w_pop += int'(w_hit_nx[k]);
    w_hcnt = (CNT_W < 31 && w_pop >= (1 << CNT_W)) ? '1 : CNT_W'(w_pop);
    w_state_nx = r_state == ARMED ? (w_viol ? FAIL : w_done ? PASS : w_tmo ? FAIL : ARMED)
                                  : (bus.start ? ARMED : r_state);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCHK; k++) begin
        r_mode[k] <= '0;
        r_pc[k]   <= '0;
        r_epc[k]  <= '0;
      end
      r_mie   <= '0;
      r_hit   <= '0;
      r_rv    <= 1'b0;
      r_rmie  <= 1'b0;
      r_rpc   <= '0;
      r_repc  <= '0;
      r_tmo   <= '0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_fidx  <= '0;
      r_fcode <= '0;
      r_hcnt  <= '0;
    end else begin
      r_rv   <= bus.retire_valid;
      r_rpc  <= bus.retire_pc;
      r_rmie <= bus.mstatus_mie;
      r_repc <= bus.mepc;
      for (int k = 0; k < NCHK; k++)
        if (bus.cfg_we && r_state != ARMED && bus.cfg_idx == IDX_W'(k)) begin
          r_mode[k] <= bus.cfg_mode;
          r_pc[k]   <= bus.cfg_pc;
          r_mie[k]  <= bus.cfg_mie;
          r_epc[k]  <= bus.cfg_epc;
        end
      if (r_state != ARMED && bus.start) begin
        r_hit   <= '0;
        r_tmo   <= '0;
        r_pass  <= 1'b0;
        r_fail  <= 1'b0;
        r_fidx  <= '0;
        r_fcode <= '0;
        r_hcnt  <= '0;
      end else if (r_state == ARMED) begin
        r_tmo <= w_tmo_nx;
        if (w_viol) begin
          r_fail  <= 1'b1;
          r_fidx  <= w_fidx;
          r_fcode <= w_fcode;
        end else begin
          r_hit  <= w_hit_nx;
          r_hcnt <= w_hcnt;
          r_pass <= w_done;
          if (!w_done && w_tmo) begin
            r_fail  <= 1'b1;
            r_fidx  <= '0;
            r_fcode <= 3'd5;
          end
        end
      end
    end
  end
  assign bus.busy      = r_state == ARMED;
  assign bus.pass      = r_pass;
  assign bus.fail      = r_fail;
  assign bus.fail_idx  = r_fidx;
  assign bus.fail_code = r_fcode;
  assign bus.hit_cnt   = r_hcnt;
endmodule

// File: tb/tb_trap_checkpoint_monitor.sv
// tb_trap_checkpoint_monitor: ordered (inst0) and unordered (inst1) monitors against a behavioural model
module tb_trap_checkpoint_monitor;
  logic clk = 1'b0, reset = 1'b1;
  logic cfg_we = 1'b0, cfg_mie = 1'b0, start = 1'b0, rv = 1'b0, rmie = 1'b0;
  logic [1:0] cfg_idx = '0, cfg_mode = '0;
  logic [31:0] cfg_pc = '0, cfg_epc = '0, rpc = '0, repc = '0;
  logic [15:0] tmo_lim = '0;
  logic o_busy [2], o_pass [2], o_fail [2];
  logic [1:0] o_fidx [2];
  logic [2:0] o_fcode [2];
  logic [7:0] o_hcnt [2];
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  trap_checkpoint_monitor_if #(.XLEN(32), .NCHK(4), .TMO_W(16), .CNT_W(8)) bus [2] ();
  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].cfg_we       = cfg_we;
    assign bus[g].cfg_idx      = cfg_idx;
    assign bus[g].cfg_mode     = cfg_mode;
    assign bus[g].cfg_pc       = cfg_pc;
    assign bus[g].cfg_mie      = cfg_mie;
    assign bus[g].cfg_epc      = cfg_epc;
    assign bus[g].tmo_lim      = tmo_lim;
    assign bus[g].start        = start;
    assign bus[g].retire_valid = rv;
    assign bus[g].retire_pc    = rpc;
    assign bus[g].mstatus_mie  = rmie;
    assign bus[g].mepc         = repc;
    assign o_busy[g]  = bus[g].busy;
    assign o_pass[g]  = bus[g].pass;
    assign o_fail[g]  = bus[g].fail;
    assign o_fidx[g]  = bus[g].fail_idx;
    assign o_fcode[g] = bus[g].fail_code;
    assign o_hcnt[g]  = bus[g].hit_cnt;
    trap_checkpoint_monitor #(.XLEN(32), .NCHK(4), .ORDERED(g == 0), .TMO_W(16), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .bus(bus[g]));
  end
  // behavioural model: per instance a table, a hit set and a status record
  int mt_mode [2][4];
  logic [31:0] mt_pc [2][4], mt_epc [2][4];
  bit mt_mie [2][4], m_hit [2][4];
  bit m_busy [2], m_pass [2], m_fail [2];
  int m_fidx [2], m_fcode [2], m_hcnt [2], m_tmo [2];
  bit p_rv, p_mie;
  logic [31:0] p_pc, p_epc;
  logic [31:0] sw_pc [4], sw_epc [4];
  bit sw_mie [4];
  task automatic chk(input string n, input int g, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s inst%0d got=0x%0h exp=0x%0h", n, g, a, e);
    end
  endtask
  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++) begin
        mt_mode[g][k] = 0; mt_pc[g][k] = 0; mt_epc[g][k] = 0; mt_mie[g][k] = 0; m_hit[g][k] = 0;
      end
      m_busy[g] = 0; m_pass[g] = 0; m_fail[g] = 0; m_fidx[g] = 0; m_fcode[g] = 0; m_hcnt[g] = 0; m_tmo[g] = 0;
    end
    p_rv = 0; p_mie = 0; p_pc = 0; p_epc = 0;
  endtask
  task automatic mfail(input int g, input int i, input int c);
    m_fail[g] = 1; m_busy[g] = 0; m_fidx[g] = i; m_fcode[g] = c;
  endtask
  task automatic model_eval(input int g);
    int ptr = -1, bidx = -1, bcode = 0, oidx = -1, hits = 0, code;
    bit fresh = 0, all = 1;
    bit ok [4];
    for (int k = 0; k < 4; k++) begin
      ok[k] = 0;
      if (ptr < 0 && mt_mode[g][k] != 0 && !m_hit[g][k]) ptr = k;
    end
    for (int k = 0; k < 4; k++)
      if (p_rv && mt_mode[g][k] != 0 && p_pc == mt_pc[g][k]) begin
        code = 0;
        if ((mt_mode[g][k] & 1) != 0 && p_mie != mt_mie[g][k]) code += 1;
        if ((mt_mode[g][k] & 2) != 0 && p_epc != mt_epc[g][k]) code += 2;
        if (g == 1 || k == ptr) begin
          if (code != 0) begin
            if (bidx < 0) begin bidx = k; bcode = code; end
          end else ok[k] = 1;
        end else if (!m_hit[g][k] && oidx < 0) oidx = k;
      end
    if (bidx >= 0) mfail(g, bidx, bcode);
    else if (oidx >= 0) mfail(g, oidx, 4);
    else begin
      for (int k = 0; k < 4; k++)
        if (ok[k] && !m_hit[g][k]) begin m_hit[g][k] = 1; fresh = 1; end
      m_tmo[g] = fresh ? 0 : m_tmo[g] + 1;
      for (int k = 0; k < 4; k++) begin
        hits += int'(m_hit[g][k]);
        if (mt_mode[g][k] != 0 && !m_hit[g][k]) all = 0;
      end
      m_hcnt[g] = hits;
      if (all) begin m_pass[g] = 1; m_busy[g] = 0; end
      else if (tmo_lim != 0 && m_tmo[g] == int'(tmo_lim)) mfail(g, 0, 5);
    end
  endtask
  task automatic model_step();
    if (reset) begin model_reset(); return; end
    for (int g = 0; g < 2; g++)
      if (m_busy[g]) model_eval(g);
      else begin
        if (cfg_we) begin
          mt_mode[g][cfg_idx] = int'(cfg_mode); mt_pc[g][cfg_idx] = cfg_pc;
          mt_mie[g][cfg_idx] = cfg_mie; mt_epc[g][cfg_idx] = cfg_epc;
        end
        if (start) begin
          for (int k = 0; k < 4; k++) m_hit[g][k] = 0;
          m_busy[g] = 1; m_pass[g] = 0; m_fail[g] = 0; m_fidx[g] = 0; m_fcode[g] = 0; m_hcnt[g] = 0; m_tmo[g] = 0;
        end
      end
    p_rv = rv; p_pc = rpc; p_mie = rmie; p_epc = repc;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic wr(input int i, input int mode, input logic [31:0] pc, input bit mie, input logic [31:0] epc);
    cfg_idx = 2'(i); cfg_mode = 2'(mode); cfg_pc = pc; cfg_mie = mie; cfg_epc = epc; cfg_we = 1;
    sw_pc[i] = pc; sw_mie[i] = mie; sw_epc[i] = epc;
    tick();
    cfg_we = 0;
  endtask
  task automatic arm();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic ret(input logic [31:0] pc, input bit mie, input logic [31:0] epc);
    rv = 1; rpc = pc; rmie = mie; repc = epc;
    tick();
    rv = 0;
  endtask
  always @(negedge clk)
    if (chk_en)
      for (int g = 0; g < 2; g++) begin
        chk("busy", g, o_busy[g], m_busy[g]);
        chk("pass", g, o_pass[g], m_pass[g]);
        chk("fail", g, o_fail[g], m_fail[g]);
        chk("fail_idx", g, o_fidx[g], m_fidx[g]);
        chk("fail_code", g, o_fcode[g], m_fcode[g]);
        chk("hit_cnt", g, o_hcnt[g], m_hcnt[g]);
      end
  initial begin
    model_reset();
    repeat (3) tick();
    reset = 0;
    chk_en = 1;
    for (int i = 0; i < 100; i++) begin
      rv = 1'($urandom_range(0, 1)); rpc = 32'h0a0 + 32'($urandom_range(0, 2)) * 32'h5c; rmie = 1'($urandom_range(0, 1));
      tick();
    end
    rv = 0;
    for (int g = 0; g < 2; g++) begin
      chk("t1_busy", g, o_busy[g], 0); chk("t1_pass", g, o_pass[g], 0);
      chk("t1_fail", g, o_fail[g], 0); chk("t1_hit_cnt", g, o_hcnt[g], 0);
    end
    wr(0, 1, 32'h0a0, 1, 0); wr(1, 1, 32'h158, 0, 0); wr(2, 2, 32'h19c, 0, 32'h0a0);
    arm();
    ret(32'h0a0, 1, 0); ret(32'h158, 0, 0); ret(32'h19c, 0, 32'h0a0);
    chk("t2_pass_early", 0, o_pass[0], 0);
    tick();
    chk("t2_pass", 0, o_pass[0], 1); chk("t2_hit_cnt", 0, o_hcnt[0], 3); chk("t2_busy", 0, o_busy[0], 0);
    arm();
    ret(32'h0a0, 1, 0); ret(32'h158, 1, 0);
    chk("t3_fail_early", 0, o_fail[0], 0);
    tick();
    for (int g = 0; g < 2; g++) begin
      chk("t3_fail", g, o_fail[g], 1); chk("t3_fail_idx", g, o_fidx[g], 1); chk("t3_fail_code", g, o_fcode[g], 1);
    end
    arm();
    ret(32'h0a0, 1, 0); ret(32'h19c, 0, 32'h0a0);
    tick();
    chk("t4_fail", 0, o_fail[0], 1); chk("t4_fail_idx", 0, o_fidx[0], 2); chk("t4_fail_code", 0, o_fcode[0], 4);
    chk("t4_busy", 1, o_busy[1], 1); chk("t4_hit_cnt", 1, o_hcnt[1], 2);
    ret(32'h158, 0, 0);
    tick();
    chk("t4_pass", 1, o_pass[1], 1); chk("t4_still_fail", 0, o_fail[0], 1);
    tmo_lim = 10;
    arm();
    ret(32'h0a0, 1, 0);
    repeat (10) tick();
    chk("t5_fail_early", 0, o_fail[0], 0);
    tick();
    for (int g = 0; g < 2; g++) begin
      chk("t5_fail", g, o_fail[g], 1); chk("t5_fail_code", g, o_fcode[g], 5); chk("t5_fail_idx", g, o_fidx[g], 0);
    end
    tmo_lim = 0;
    wr(0, 3, 32'h100, 1, 32'h200); wr(1, 1, 32'h104, 0, 0); wr(2, 2, 32'h108, 0, 32'h204); wr(3, 3, 32'h10c, 0, 32'h208);
    arm();
    ret(32'h10c, 0, 32'h208); ret(32'h104, 0, 0); ret(32'h100, 1, 32'h200); ret(32'h108, 1, 32'h204);
    tick();
    chk("t6_pass", 1, o_pass[1], 1); chk("t6_hit_cnt", 1, o_hcnt[1], 4);
    chk("t6_ord_idx", 0, o_fidx[0], 3); chk("t6_ord_code", 0, o_fcode[0], 4);
    arm();
    ret(32'h10c, 0, 32'h208);
    tick();
    #2 reset = 1;
    model_reset();
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("t6_rst_busy", g, o_busy[g], 0); chk("t6_rst_pass", g, o_pass[g], 0); chk("t6_rst_fail", g, o_fail[g], 0);
      chk("t6_rst_hit_cnt", g, o_hcnt[g], 0); chk("t6_rst_fail_code", g, o_fcode[g], 0);
    end
    tick(); tick();
    reset = 0;
    arm();
    tick();
    chk("t6_empty_pass", 0, o_pass[0], 1); chk("t6_empty_hit_cnt", 0, o_hcnt[0], 0);
    for (int r = 0; r < 40; r++) begin
      tmo_lim = $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom_range(4, 20));
      for (int k = 0; k < 4; k++)
        wr(k, int'($urandom_range(0, 3)), 32'h40 * 32'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
           32'h4 * 32'($urandom_range(0, 1)));
      arm();
      for (int c = 0; c < 40; c++) begin
        int e = int'($urandom_range(0, 3));
        rv = $urandom_range(0, 9) < 7;
        if ($urandom_range(0, 4) != 0) begin
          rpc = sw_pc[e]; rmie = sw_mie[e]; repc = sw_epc[e];
        end else begin
          rpc = 32'h40 * 32'($urandom_range(1, 5)); rmie = 1'($urandom_range(0, 1)); repc = 32'h4 * 32'($urandom_range(0, 1));
        end
        start = $urandom_range(0, 19) == 0;
        cfg_we = $urandom_range(0, 19) == 0;
        cfg_idx = 2'($urandom_range(0, 3)); cfg_mode = 2'($urandom_range(0, 3));
        cfg_pc = 32'h40 * 32'($urandom_range(1, 4)); cfg_mie = 1'($urandom_range(0, 1)); cfg_epc = 32'h4 * 32'($urandom_range(0, 1));
        tick();
      end
      rv = 0; start = 0; cfg_we = 0;
    end
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
